clause_array_ctrl: RTL and testbench
====================================

// Module: clause_array_ctrl
// PURPOSE
//  Sequencer in front of clause_array. Loads a clause bin row-by-row over a valid/ready stream
//  (one-hot wr, one clause per cycle), then runs implication passes until var values settle or
//  a conflict is flagged, and issues backtrack passes. Sits between the bin manager and clause_array.
// PARAMETERS
//  NUM_CLAUSES   8    clause rows in the driven clause_array
//  NUM_VARS      8    variables per row; 3-bit value code per var (sat_pkg encoding)
//  WIDTH_C_LEN   4    clause length field width
//  MAX_BCP_CYC   32   implication-pass cycle budget before timeout
// PORTS
//  clk              in   1                  clock
//  rst              in   1                  synchronous, active-high reset
//  load_start_i     in   1                  pulse: begin loading a new bin (IDLE only)
//  cl_valid_i       in   1                  clause beat valid
//  cl_ready_o       out  1                  clause beat accepted when valid&ready
//  cl_last_i        in   1                  final clause of bin
//  cl_len_i         in   WIDTH_C_LEN        clause length
//  cl_lits_i        in   NUM_VARS*3         clause literal row
//  bcp_start_i      in   1                  pulse: run implication to fixpoint
//  bkt_start_i      in   1                  pulse: run one backtrack pass
//  ca_wr_o          out  NUM_CLAUSES        one-hot row write to clause_array
//  ca_clause_len_o  out  WIDTH_C_LEN        to clause_array clause_len_i
//  ca_var_value_o   out  NUM_VARS*3         to clause_array var_value_i
//  ca_var_value_i   in   NUM_VARS*3         from clause_array var_value_o
//  ca_conflict_i    in   1                  any clause falsified
//  ca_apply_impl_o  out  1                  to clause_array apply_impl_i
//  ca_apply_bkt_o   out  1                  to clause_array apply_bkt_i
//  busy_o           out  1                  state != IDLE
//  done_o           out  1                  1-cycle pulse at end of load/bcp/bkt
//  conflict_o       out  1                  sticky: last bcp ended in conflict
//  timeout_o        out  1                  sticky: last bcp exhausted MAX_BCP_CYC
//  overflow_o       out  1                  sticky: > NUM_CLAUSES beats offered
//  loaded_cnt_o     out  $clog2(NUM_CLAUSES+1)  rows written in current bin
// BEHAVIOUR
//  Reset: state IDLE; all outputs 0; row pointer 0; stickies cleared. Mid-operation reset
//   aborts at next edge, ca_wr_o=0 same cycle.
//  FSM IDLE->LOAD->FLUSH->IDLE; IDLE->BCP->IDLE; IDLE->BKT->IDLE.
//  IDLE: load_start_i -> LOAD, loaded_cnt=0, overflow/conflict/timeout cleared. Else
//   bkt_start_i -> BKT. Else bcp_start_i -> BCP. Priority load > bkt > bcp. Starts ignored when busy.
//  LOAD: cl_ready_o=1 while ptr<NUM_CLAUSES. Accepted beat registered: next cycle
//   ca_wr_o[ptr]=1 with len/lits (1-cycle latency); ptr++. On accepted cl_last_i, after its
//   write cycle: -> FLUSH. Rows not written keep old content (caller zero-fills).
//  Full: ptr==NUM_CLAUSES -> cl_ready_o=0; valid held 1 cycle -> overflow_o=1, -> FLUSH.
//  FLUSH: one cycle ca_wr_o=0 (array settle); done_o=1; -> IDLE.
//  BCP: ca_apply_impl_o=1 each cycle; ca_var_value_o held at 0 (no new assignment); snapshot
//   prev <= ca_var_value_i. Exit when ca_var_value_i==prev for 1 cycle (fixpoint, min 2 cycles),
//   or ca_conflict_i=1 (conflict_o=1, exits same cycle), or counter==MAX_BCP_CYC (timeout_o=1).
//   Conflict and fixpoint same cycle -> conflict wins. Exit: apply_impl drops, done_o=1.
//  BKT: ca_apply_bkt_o=1 for exactly 1 cycle, then done_o next cycle -> IDLE.
//  apply_impl and apply_bkt never high together; ca_wr_o never nonzero outside LOAD.
// STRUCTURE
//  sat_pkg: var value code localparams (FREE/POS/NEG, IMP bit), ctrl_state_t enum.
//  One sub-module: ca_load_seq (ptr, one-hot decode, overflow); FSM and BCP monitor in top.
// TESTING
//  rst high 2 cycles mid-LOAD (ptr=3) -> ca_wr_o=0, busy_o=0, loaded_cnt_o=0, cl_ready_o=0.
//  Load 5 rows (bin1 pattern), last on row 4 -> ca_wr_o 00000001..00010000 one per beat, FLUSH, done_o, loaded_cnt_o=5.
//  Offer 9 beats, cl_last_i never -> 8 writes, cl_ready_o=0 at ptr=8, overflow_o=1, done_o.
//  bcp_start with array settling after 3 changes -> apply_impl high 4 cycles, done_o, conflict_o=0.
//  bcp_start, ca_conflict_i on cycle 2 -> apply_impl drops cycle 3, conflict_o=1; never-stable model -> timeout_o at 32.
//  bkt_start and bcp_start same cycle in IDLE -> single apply_bkt pulse, no apply_impl, done_o next cycle.

Source files
------------

// File: rtl/sat_pkg.sv
// -----------------------------------------------------------------------------
// sat_pkg
// Shared definitions for the SAT clause-array front end.
//   - 3-bit per-variable value codes (FREE / POS / NEG plus an implied flag bit)
//   - ctrl_state_t: sequencer states of clause_array_ctrl
// -----------------------------------------------------------------------------
package sat_pkg;

    // Per-variable value code, 3 bits per variable in every row/vector.
    localparam logic [2:0] VAL_FREE    = 3'b000;
    localparam logic [2:0] VAL_POS     = 3'b001;
    localparam logic [2:0] VAL_NEG     = 3'b010;
    // Bit index set when the value was produced by implication, not a decision.
    localparam int         VAL_IMP_BIT = 2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_FLUSH,
        ST_BCP,
        ST_BKT
    } ctrl_state_t;

endpackage

// File: rtl/ca_load_seq.sv
// -----------------------------------------------------------------------------
// ca_load_seq
// Row-load sequencer for clause_array. Accepts clause beats on a valid/ready
// stream and turns each accepted beat into a one-cycle one-hot row write on
// the following cycle (registered len/lits alongside).
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   clr_i         restart a bin: pointer and pending state cleared
//   en_i          sequencer is in its LOAD state
//   cl_valid_i    beat valid;  cl_last_i final beat of the bin
//   cl_len_i      clause length; cl_lits_i clause literal row
//   cl_ready_o    beat accepted when valid & ready
//   wr_o          one-hot row write (registered, 1 cycle after accept)
//   len_o/lits_o  row data for the write; zero in non-write cycles
//   cnt_o         rows accepted in the current bin
//   finish_o      write cycle of the last beat is in progress
//   ovf_o         a beat is offered while all rows are already used
// -----------------------------------------------------------------------------
module ca_load_seq
    import sat_pkg::*;
#(
    parameter int NUM_CLAUSES = 8,
    parameter int NUM_VARS    = 8,
    parameter int WIDTH_C_LEN = 4,
    parameter int CNT_W       = $clog2(NUM_CLAUSES + 1)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      clr_i,
    input  logic                      en_i,
    input  logic                      cl_valid_i,
    input  logic                      cl_last_i,
    input  logic [WIDTH_C_LEN-1:0]    cl_len_i,
    input  logic [NUM_VARS*3-1:0]     cl_lits_i,
    output logic                      cl_ready_o,
    output logic [NUM_CLAUSES-1:0]    wr_o,
    output logic [WIDTH_C_LEN-1:0]    len_o,
    output logic [NUM_VARS*3-1:0]     lits_o,
    output logic [CNT_W-1:0]          cnt_o,
    output logic                      finish_o,
    output logic                      ovf_o
);

    localparam logic [CNT_W-1:0] ROWS_FULL = CNT_W'(NUM_CLAUSES);

    logic [CNT_W-1:0]       r_ptr;
    logic [NUM_CLAUSES-1:0] r_wr;
    logic [WIDTH_C_LEN-1:0] r_len;
    logic [NUM_VARS*3-1:0]  r_lits;
    logic                   r_last_acc;

    logic w_ready;
    logic w_accept;

    // Once the last beat is taken the stream is closed for this bin.
    assign w_ready  = en_i && !r_last_acc && (r_ptr < ROWS_FULL);
    assign w_accept = w_ready && cl_valid_i;

    // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst || clr_i) begin
            r_ptr      <= '0;
            r_wr       <= '0;
            r_len      <= '0;
            r_lits     <= '0;
            r_last_acc <= 1'b0;
        end else begin
            // Row data is zero outside write cycles so the shared var-value
            // bus reads 0 whenever no row is being written.
            r_wr   <= w_accept ? (NUM_CLAUSES'(1) << r_ptr) : '0;
            r_len  <= w_accept ? cl_len_i : '0;
            r_lits <= w_accept ? cl_lits_i : '0;
            if (w_accept) begin
                r_ptr      <= r_ptr + 1'b1;
                r_last_acc <= cl_last_i;
            end
        end
    end

    assign cl_ready_o = w_ready;
    assign wr_o       = r_wr;
    assign len_o      = r_len;
    assign lits_o     = r_lits;
    assign cnt_o      = r_ptr;
    assign finish_o   = en_i && r_last_acc;
    assign ovf_o      = en_i && !r_last_acc && (r_ptr == ROWS_FULL) && cl_valid_i;

endmodule

// File: rtl/clause_array_ctrl.sv
// -----------------------------------------------------------------------------
// clause_array_ctrl
// Sequencer in front of clause_array: loads a clause bin row by row, runs
// implication passes to a fixpoint (or conflict / cycle budget), and issues
// single-cycle backtrack passes.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   load/bkt/bcp_start_i     operation start pulses, honoured in IDLE only
//   cl_valid/ready/last, cl_len_i, cl_lits_i   clause beat stream
//   ca_wr_o, ca_clause_len_o, ca_var_value_o   row write / value bus to array
//   ca_var_value_i, ca_conflict_i              array status
//   ca_apply_impl_o, ca_apply_bkt_o            pass strobes to array
//   busy_o, done_o                             status; done is a 1-cycle pulse
//   conflict_o, timeout_o, overflow_o          sticky outcome flags
//   loaded_cnt_o                               rows written in current bin
// -----------------------------------------------------------------------------
module clause_array_ctrl
    import sat_pkg::*;
#(
    parameter int NUM_CLAUSES = 8,
    parameter int NUM_VARS    = 8,
    parameter int WIDTH_C_LEN = 4,
    parameter int MAX_BCP_CYC = 32
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               load_start_i,
    input  logic                               cl_valid_i,
    output logic                               cl_ready_o,
    input  logic                               cl_last_i,
    input  logic [WIDTH_C_LEN-1:0]             cl_len_i,
    input  logic [NUM_VARS*3-1:0]              cl_lits_i,
    input  logic                               bcp_start_i,
    input  logic                               bkt_start_i,
    output logic [NUM_CLAUSES-1:0]             ca_wr_o,
    output logic [WIDTH_C_LEN-1:0]             ca_clause_len_o,
    output logic [NUM_VARS*3-1:0]              ca_var_value_o,
    input  logic [NUM_VARS*3-1:0]              ca_var_value_i,
    input  logic                               ca_conflict_i,
    output logic                               ca_apply_impl_o,
    output logic                               ca_apply_bkt_o,
    output logic                               busy_o,
    output logic                               done_o,
    output logic                               conflict_o,
    output logic                               timeout_o,
    output logic                               overflow_o,
    output logic [$clog2(NUM_CLAUSES+1)-1:0]   loaded_cnt_o
);

    localparam int                BCNT_W    = $clog2(MAX_BCP_CYC + 1);
    localparam logic [BCNT_W-1:0] BCP_LIMIT = BCNT_W'(MAX_BCP_CYC);
    localparam logic [BCNT_W-1:0] BCP_MIN   = BCNT_W'(2);

    ctrl_state_t           r_state;
    logic                  r_apply_impl;
    logic                  r_apply_bkt;
    logic                  r_done;
    logic                  r_conflict;
    logic                  r_timeout;
    logic                  r_overflow;
    logic [BCNT_W-1:0]     r_bcp_cnt;
    logic [NUM_VARS*3-1:0] r_prev;

    logic                  w_clr;
    logic                  w_finish;
    logic                  w_ovf;
    logic                  w_fixpoint;
    logic [NUM_CLAUSES-1:0] w_wr;

    assign w_clr = (r_state == ST_IDLE) && load_start_i;

    ca_load_seq #(
        .NUM_CLAUSES (NUM_CLAUSES),
        .NUM_VARS    (NUM_VARS),
        .WIDTH_C_LEN (WIDTH_C_LEN)
    ) u_load_seq (
        .clk        (clk),
        .rst        (rst),
        .clr_i      (w_clr),
        .en_i       (r_state == ST_LOAD),
        .cl_valid_i (cl_valid_i),
        .cl_last_i  (cl_last_i),
        .cl_len_i   (cl_len_i),
        .cl_lits_i  (cl_lits_i),
        .cl_ready_o (cl_ready_o),
        .wr_o       (w_wr),
        .len_o      (ca_clause_len_o),
        .lits_o     (ca_var_value_o),
        .cnt_o      (loaded_cnt_o),
        .finish_o   (w_finish),
        .ovf_o      (w_ovf)
    );

    // Reset suppresses a pending row write in the very cycle it is raised,
    // so an aborted load never corrupts the array.
    assign ca_wr_o = rst ? '0 : w_wr;

    // The first BCP cycle has no valid snapshot yet, hence the 2-cycle floor.
    assign w_fixpoint = (r_bcp_cnt >= BCP_MIN) && (ca_var_value_i == r_prev);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_apply_impl <= 1'b0;
            r_apply_bkt  <= 1'b0;
            r_done       <= 1'b0;
            r_conflict   <= 1'b0;
            r_timeout    <= 1'b0;
            r_overflow   <= 1'b0;
            r_bcp_cnt    <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (load_start_i) begin
                        r_state    <= ST_LOAD;
                        r_overflow <= 1'b0;
                        r_conflict <= 1'b0;
                        r_timeout  <= 1'b0;
                    end else if (bkt_start_i) begin
                        r_state     <= ST_BKT;
                        r_apply_bkt <= 1'b1;
                    end else if (bcp_start_i) begin
                        // Outcome flags describe the most recent pass only.
                        r_state      <= ST_BCP;
                        r_apply_impl <= 1'b1;
                        r_bcp_cnt    <= BCNT_W'(1);
                        r_conflict   <= 1'b0;
                        r_timeout    <= 1'b0;
                    end
                end
                ST_LOAD: begin
                    if (w_ovf) begin
                        r_overflow <= 1'b1;
                        r_state    <= ST_FLUSH;
                        r_done     <= 1'b1;
                    end else if (w_finish) begin
                        r_state <= ST_FLUSH;
                        r_done  <= 1'b1;
                    end
                end
                ST_FLUSH: begin
                    r_state <= ST_IDLE;
                end
                ST_BCP: begin
                    r_bcp_cnt <= r_bcp_cnt + 1'b1;
                    // Conflict takes precedence over fixpoint and budget.
                    if (ca_conflict_i || w_fixpoint || (r_bcp_cnt == BCP_LIMIT)) begin
                        r_state      <= ST_IDLE;
                        r_apply_impl <= 1'b0;
                        r_done       <= 1'b1;
                        if (ca_conflict_i) begin
                            r_conflict <= 1'b1;
                        end else if (!w_fixpoint) begin
                            r_timeout <= 1'b1;
                        end
                    end
                end
                ST_BKT: begin
                    r_apply_bkt <= 1'b0;
                    r_done      <= 1'b1;
                    r_state     <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // NOTE: the snapshot has no reset; it is always loaded before the fixpoint compare reads it.
    always_ff @(posedge clk) begin
        if (r_state == ST_BCP) begin
            r_prev <= ca_var_value_i;
        end
    end

    assign ca_apply_impl_o = r_apply_impl;
    assign ca_apply_bkt_o  = r_apply_bkt;
    assign busy_o          = (r_state != ST_IDLE);
    assign done_o          = r_done;
    assign conflict_o      = r_conflict;
    assign timeout_o       = r_timeout;
    assign overflow_o      = r_overflow;

endmodule

// File: tb/tb_clause_array_ctrl.sv
// -----------------------------------------------------------------------------
// tb_clause_array_ctrl
// Directed bench for clause_array_ctrl: a per-cycle vector table for a 5-row
// bin load, plus hand-written sequences for reset abort, overflow, start
// priority, implication fixpoint / conflict / timeout and backtrack.
// Inputs change on the falling edge; outputs are compared 1 time unit later.
// -----------------------------------------------------------------------------
module tb_clause_array_ctrl;
    import sat_pkg::*;

    localparam int NC = 8;
    localparam int NV = 8;
    localparam int WL = 4;
    localparam int MB = 32;
    localparam int CW = $clog2(NC + 1);

    logic            clk = 1'b0;
    logic            rst;
    logic            load_start_i, cl_valid_i, cl_ready_o, cl_last_i;
    logic [WL-1:0]   cl_len_i;
    logic [NV*3-1:0] cl_lits_i;
    logic            bcp_start_i, bkt_start_i;
    logic [NC-1:0]   ca_wr_o;
    logic [WL-1:0]   ca_clause_len_o;
    logic [NV*3-1:0] ca_var_value_o, ca_var_value_i;
    logic            ca_conflict_i, ca_apply_impl_o, ca_apply_bkt_o;
    logic            busy_o, done_o, conflict_o, timeout_o, overflow_o;
    logic [CW-1:0]   loaded_cnt_o;

    clause_array_ctrl #(
        .NUM_CLAUSES (NC), .NUM_VARS (NV), .WIDTH_C_LEN (WL), .MAX_BCP_CYC (MB)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .load_start_i    (load_start_i),
        .cl_valid_i      (cl_valid_i),
        .cl_ready_o      (cl_ready_o),
        .cl_last_i       (cl_last_i),
        .cl_len_i        (cl_len_i),
        .cl_lits_i       (cl_lits_i),
        .bcp_start_i     (bcp_start_i),
        .bkt_start_i     (bkt_start_i),
        .ca_wr_o         (ca_wr_o),
        .ca_clause_len_o (ca_clause_len_o),
        .ca_var_value_o  (ca_var_value_o),
        .ca_var_value_i  (ca_var_value_i),
        .ca_conflict_i   (ca_conflict_i),
        .ca_apply_impl_o (ca_apply_impl_o),
        .ca_apply_bkt_o  (ca_apply_bkt_o),
        .busy_o          (busy_o),
        .done_o          (done_o),
        .conflict_o      (conflict_o),
        .timeout_o       (timeout_o),
        .overflow_o      (overflow_o),
        .loaded_cnt_o    (loaded_cnt_o)
    );

    always #5 clk = ~clk;

    int n_vec  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic set_in(input logic ls, input logic bk, input logic bc,
                          input logic v, input logic lst,
                          input logic [WL-1:0] len, input logic [NV*3-1:0] lits);
        load_start_i = ls;
        bkt_start_i  = bk;
        bcp_start_i  = bc;
        cl_valid_i   = v;
        cl_last_i    = lst;
        cl_len_i     = len;
        cl_lits_i    = lits;
    endtask

    // One octal digit per variable: 1 = POS, 2 = NEG.
    localparam logic [NV*3-1:0] R0 = 24'o00000021;
    localparam logic [NV*3-1:0] R1 = 24'o00000102;
    localparam logic [NV*3-1:0] R2 = 24'o00001200;
    localparam logic [NV*3-1:0] R3 = 24'o02010000;
    localparam logic [NV*3-1:0] R4 = 24'o10020001;

    // Array value snapshots for the implication tests.
    localparam logic [NV*3-1:0] VA = 24'o00000001;
    localparam logic [NV*3-1:0] VB = 24'o00000021;
    localparam logic [NV*3-1:0] VC = 24'o00000621;

    typedef struct {
        logic            ls, v, last;
        logic [WL-1:0]   len;
        logic [NV*3-1:0] lits;
        logic            rdy;
        logic [NC-1:0]   wr;
        logic [WL-1:0]   wlen;
        logic [NV*3-1:0] vv;
        logic            done, busy;
        logic [CW-1:0]   cnt;
    } vec_t;

    vec_t tbl[10];

    initial begin
        // Bin 1: 5 rows, one bubble after row 1, last on row 4.
        //           ls    v     last  len  lits   rdy   wr     wlen vv  done  busy  cnt
        tbl[0] = '{1'b1, 1'b0, 1'b0, 4'd0, '0,  1'b0, 8'h00, 4'd0, '0, 1'b0, 1'b0, 4'd0};
        tbl[1] = '{1'b0, 1'b1, 1'b0, 4'd2, R0,  1'b1, 8'h00, 4'd0, '0, 1'b0, 1'b1, 4'd0};
        tbl[2] = '{1'b0, 1'b1, 1'b0, 4'd2, R1,  1'b1, 8'h01, 4'd2, R0, 1'b0, 1'b1, 4'd1};
        tbl[3] = '{1'b0, 1'b0, 1'b0, 4'd0, '0,  1'b1, 8'h02, 4'd2, R1, 1'b0, 1'b1, 4'd2};
        tbl[4] = '{1'b0, 1'b1, 1'b0, 4'd2, R2,  1'b1, 8'h00, 4'd0, '0, 1'b0, 1'b1, 4'd2};
        tbl[5] = '{1'b0, 1'b1, 1'b0, 4'd2, R3,  1'b1, 8'h04, 4'd2, R2, 1'b0, 1'b1, 4'd3};
        tbl[6] = '{1'b0, 1'b1, 1'b1, 4'd3, R4,  1'b1, 8'h08, 4'd2, R3, 1'b0, 1'b1, 4'd4};
        tbl[7] = '{1'b0, 1'b0, 1'b0, 4'd0, '0,  1'b0, 8'h10, 4'd3, R4, 1'b0, 1'b1, 4'd5};
        tbl[8] = '{1'b0, 1'b0, 1'b0, 4'd0, '0,  1'b0, 8'h00, 4'd0, '0, 1'b1, 1'b1, 4'd5};
        tbl[9] = '{1'b0, 1'b0, 1'b0, 4'd0, '0,  1'b0, 8'h00, 4'd0, '0, 1'b0, 1'b0, 4'd5};

        // ---------------- reset state ----------------
        rst            = 1'b1;
        ca_var_value_i = '0;
        ca_conflict_i  = 1'b0;
        set_in(0, 0, 0, 0, 0, '0, '0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_busy",     busy_o, 0);
        check("rst_done",     done_o, 0);
        check("rst_wr",       ca_wr_o, 0);
        check("rst_ready",    cl_ready_o, 0);
        check("rst_cnt",      loaded_cnt_o, 0);
        check("rst_stickies", {conflict_o, timeout_o, overflow_o}, 0);
        check("rst_strobes",  {ca_apply_impl_o, ca_apply_bkt_o}, 0);

        // ---------------- reset mid-LOAD at ptr=3 ----------------
        @(negedge clk); set_in(1, 0, 0, 0, 0, '0, '0);
        @(negedge clk); set_in(0, 0, 0, 1, 0, 4'd2, R0);
        @(negedge clk); set_in(0, 0, 0, 1, 0, 4'd2, R1);
        @(negedge clk); set_in(0, 0, 0, 1, 0, 4'd2, R2);
        @(negedge clk); set_in(0, 0, 0, 1, 0, 4'd2, R3);
        #1;
        check("abort_pre_cnt", loaded_cnt_o, 3);
        check("abort_pre_wr",  ca_wr_o, 8'h04);
        rst = 1'b1;
        #1;
        check("abort_wr_same_cycle", ca_wr_o, 0);
        @(negedge clk); #1;
        check("abort_wr",    ca_wr_o, 0);
        check("abort_busy",  busy_o, 0);
        check("abort_cnt",   loaded_cnt_o, 0);
        check("abort_ready", cl_ready_o, 0);
        @(negedge clk); rst = 1'b0; #1;
        check("abort_after_busy",  busy_o, 0);
        check("abort_after_ready", cl_ready_o, 0);
        check("abort_after_cnt",   loaded_cnt_o, 0);
        set_in(0, 0, 0, 0, 0, '0, '0);

        // ---------------- bin 1 load from the vector table ----------------
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            set_in(tbl[i].ls, 0, 0, tbl[i].v, tbl[i].last, tbl[i].len, tbl[i].lits);
            #1;
            check($sformatf("load%0d_ready", i), cl_ready_o, tbl[i].rdy);
            check($sformatf("load%0d_wr", i),    ca_wr_o, tbl[i].wr);
            check($sformatf("load%0d_len", i),   ca_clause_len_o, tbl[i].wlen);
            check($sformatf("load%0d_vv", i),    ca_var_value_o, tbl[i].vv);
            check($sformatf("load%0d_done", i),  done_o, tbl[i].done);
            check($sformatf("load%0d_busy", i),  busy_o, tbl[i].busy);
            check($sformatf("load%0d_cnt", i),   loaded_cnt_o, tbl[i].cnt);
            check($sformatf("load%0d_strb", i),  {ca_apply_impl_o, ca_apply_bkt_o}, 0);
        end

        // ---------------- overflow: 9 beats, no last ----------------
        @(negedge clk); set_in(1, 0, 0, 0, 0, '0, '0);
        for (int k = 0; k <= 8; k++) begin
            @(negedge clk);
            set_in(0, 0, 0, 1, 0, 4'd1, 24'(k + 1));
            #1;
            check($sformatf("ovf%0d_ready", k), cl_ready_o, (k < 8) ? 1 : 0);
            check($sformatf("ovf%0d_wr", k),    ca_wr_o, (k == 0) ? 0 : (32'd1 << (k - 1)));
            check($sformatf("ovf%0d_cnt", k),   loaded_cnt_o, k);
            check($sformatf("ovf%0d_flag", k),  overflow_o, 0);
        end
        @(negedge clk); set_in(0, 0, 0, 0, 0, '0, '0); #1;
        check("ovf_flush_done", done_o, 1);
        check("ovf_flush_flag", overflow_o, 1);
        check("ovf_flush_wr",   ca_wr_o, 0);
        check("ovf_flush_cnt",  loaded_cnt_o, 8);
        @(negedge clk); #1;
        check("ovf_idle_done",  done_o, 0);
        check("ovf_idle_busy",  busy_o, 0);
        check("ovf_idle_flag",  overflow_o, 1);

        // ---------------- load wins over bkt/bcp; new load clears overflow ----------------
        @(negedge clk); set_in(1, 1, 1, 0, 0, '0, '0);
        @(negedge clk); set_in(0, 0, 0, 1, 1, 4'd3, R4); #1;
        check("prio_ready",   cl_ready_o, 1);
        check("prio_strobes", {ca_apply_impl_o, ca_apply_bkt_o}, 0);
        check("prio_ovf_clr", overflow_o, 0);
        check("prio_cnt",     loaded_cnt_o, 0);
        @(negedge clk); set_in(0, 0, 0, 0, 0, '0, '0); #1;
        check("prio_wr",      ca_wr_o, 8'h01);
        check("prio_ready2",  cl_ready_o, 0);
        @(negedge clk); #1;
        check("prio_done",    done_o, 1);
        check("prio_cnt1",    loaded_cnt_o, 1);

        // ---------------- BCP: values A,B,C,C -> 4 implication cycles ----------------
        @(negedge clk); set_in(0, 0, 1, 0, 0, '0, '0); ca_var_value_i = VA; #1;
        check("fix_c0_impl", ca_apply_impl_o, 0);
        @(negedge clk); set_in(0, 0, 0, 0, 0, '0, '0); ca_var_value_i = VA; #1;
        check("fix_c1_impl", ca_apply_impl_o, 1);
        check("fix_c1_busy", busy_o, 1);
        check("fix_c1_vv",   ca_var_value_o, 0);
        @(negedge clk); ca_var_value_i = VB; #1;
        check("fix_c2_impl", ca_apply_impl_o, 1);
        @(negedge clk); ca_var_value_i = VC; #1;
        check("fix_c3_impl", ca_apply_impl_o, 1);
        @(negedge clk); ca_var_value_i = VC; #1;
        check("fix_c4_impl", ca_apply_impl_o, 1);
        check("fix_c4_bkt",  ca_apply_bkt_o, 0);
        @(negedge clk); #1;
        check("fix_end_impl",  ca_apply_impl_o, 0);
        check("fix_end_done",  done_o, 1);
        check("fix_end_busy",  busy_o, 0);
        check("fix_end_flags", {conflict_o, timeout_o}, 0);
        @(negedge clk); #1;
        check("fix_post_done", done_o, 0);

        // ---------------- BCP on an already-settled array: 2-cycle floor ----------------
        @(negedge clk); set_in(0, 0, 1, 0, 0, '0, '0); ca_var_value_i = VC;
        @(negedge clk); set_in(0, 0, 0, 0, 0, '0, '0); #1;
        check("min_c1_impl", ca_apply_impl_o, 1);
        @(negedge clk); #1;
        check("min_c2_impl", ca_apply_impl_o, 1);
        @(negedge clk); #1;
        check("min_end_impl", ca_apply_impl_o, 0);
        check("min_end_done", done_o, 1);

        // ---------------- BCP conflict in cycle 2 (also stable): conflict wins ----------------
        @(negedge clk); set_in(0, 0, 1, 0, 0, '0, '0); ca_var_value_i = VA;
        @(negedge clk); set_in(0, 0, 0, 0, 0, '0, '0); ca_var_value_i = VB; #1;
        check("cfl_c1_impl", ca_apply_impl_o, 1);
        @(negedge clk); ca_conflict_i = 1'b1; #1;
        check("cfl_c2_impl", ca_apply_impl_o, 1);
        @(negedge clk); ca_conflict_i = 1'b0; #1;
        check("cfl_c3_impl",     ca_apply_impl_o, 0);
        check("cfl_c3_conflict", conflict_o, 1);
        check("cfl_c3_timeout",  timeout_o, 0);
        check("cfl_c3_done",     done_o, 1);

        // ---------------- BCP never settles -> timeout after 32 cycles ----------------
        @(negedge clk); set_in(0, 0, 1, 0, 0, '0, '0);
        for (int k = 1; k <= MB; k++) begin
            @(negedge clk);
            set_in(0, 0, 0, 0, 0, '0, '0);
            ca_var_value_i = 24'(k * 9 + 5);
            #1;
            check($sformatf("tmo_c%0d_impl", k), ca_apply_impl_o, 1);
        end
        @(negedge clk); #1;
        check("tmo_end_impl",     ca_apply_impl_o, 0);
        check("tmo_end_timeout",  timeout_o, 1);
        check("tmo_end_conflict", conflict_o, 0);
        check("tmo_end_done",     done_o, 1);
        @(negedge clk); #1;
        check("tmo_sticky", timeout_o, 1);
        check("tmo_post_done", done_o, 0);

        // ---------------- bkt and bcp together: bkt wins, bcp while busy ignored ----------------
        @(negedge clk); set_in(0, 1, 1, 0, 0, '0, '0); #1;
        check("bkt_c0_bkt", ca_apply_bkt_o, 0);
        @(negedge clk); set_in(0, 0, 1, 0, 0, '0, '0); #1;
        check("bkt_c1_bkt",  ca_apply_bkt_o, 1);
        check("bkt_c1_impl", ca_apply_impl_o, 0);
        check("bkt_c1_busy", busy_o, 1);
        check("bkt_c1_done", done_o, 0);
        @(negedge clk); set_in(0, 0, 0, 0, 0, '0, '0); #1;
        check("bkt_c2_bkt",  ca_apply_bkt_o, 0);
        check("bkt_c2_impl", ca_apply_impl_o, 0);
        check("bkt_c2_done", done_o, 1);
        check("bkt_c2_busy", busy_o, 0);
        @(negedge clk); #1;
        check("bkt_c3_impl", ca_apply_impl_o, 0);
        check("bkt_c3_done", done_o, 0);
        check("bkt_c3_busy", busy_o, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
